collatz_range_ctrl: RTL and testbench

- Front-panel controller between the board I/O (KEY, SW) and the Collatz `range` engine (RAM_WORDS results, RAM_ADDR_BITS address).
- Latches a start value from the switches and pulses `go` to launch a run, then waits for `done`.
- After the run, lets the user browse stored iteration counts with pushbuttons by driving the engine's read address `n`.
- Produces the start/offset and count values that the top level feeds to the hex7seg displays (HEX5-3 start, HEX2-0 count).

---
 rtl/collatz_range_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_collatz_range_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/collatz_range_ctrl.sv
// Front-panel controller for the Collatz range engine: debounced keys, run launch and result browsing.
// Optional hold-to-repeat on up/down in BROWSE is enabled by defining COLLATZ_AUTO_REPEAT_EN.
module collatz_range_ctrl #(
    parameter int          RAM_WORDS            = 256,
    parameter int          RAM_ADDR_BITS        = 8,
`ifdef COLLATZ_AUTO_REPEAT_EN
    parameter int          REPEAT_DELAY_CYCLES  = 25_000_000,
    parameter int          REPEAT_PERIOD_CYCLES = 5_000_000,
`endif
    parameter logic [19:0] DEBOUNCE_CYCLES      = 20'd500000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  key,
    input  logic [9:0]  sw,
    input  logic        done,
    input  logic [15:0] count,
    output logic        go,
    output logic [31:0] start,
    output logic [11:0] n,
    output logic [11:0] disp_start,
    output logic [11:0] disp_count,
    output logic [9:0]  ledr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_BROWSE = 2'd3
    } state_t;

    localparam logic [RAM_ADDR_BITS-1:0] LAST_OFFSET = RAM_ADDR_BITS'(RAM_WORDS - 1);

    state_t                   state_reg, state_next;
    logic [RAM_ADDR_BITS-1:0] offset_reg, offset_next;
    logic [31:0]              start_reg, start_next;
    logic [11:0]              disp_start_reg;
    logic [11:0]              disp_count_reg;
    logic                     sat_reg;

    // key_level is the debounced raw level (1 = released); press_evt pulses once per press.
    logic [3:0] key_level;
    logic [3:0] press_evt;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key
            logic        sync1_reg, sync2_reg, level_reg, evt_reg;
            logic [19:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                    level_reg <= 1'b1;
                    evt_reg   <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= key[gi];
                    sync2_reg <= sync1_reg;
                    evt_reg   <= 1'b0;
                    if (sync2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DEBOUNCE_CYCLES - 20'd1) begin
                        cnt_reg   <= '0;
                        level_reg <= sync2_reg;
                        evt_reg   <= ~sync2_reg;
                    end else begin
                        cnt_reg <= cnt_reg + 20'd1;
                    end
                end
            end

            assign key_level[gi] = level_reg;
            assign press_evt[gi] = evt_reg;
        end
    endgenerate

    logic go_evt, home_evt, up_evt, down_evt;
    assign go_evt   = press_evt[3];
    assign home_evt = press_evt[2];

`ifdef COLLATZ_AUTO_REPEAT_EN
    // One shared repeat timer: first repeat after the long delay, then every period while held.
    logic [31:0] rpt_cnt_reg;
    logic        rpt_armed_reg;
    logic        rpt_held;
    logic        rpt_fire;

    assign rpt_held = (state_reg == S_BROWSE) && (!key_level[0] || !key_level[1]);

    always_comb begin
        rpt_fire = 1'b0;
        if (rpt_held) begin
            if (rpt_armed_reg)
                rpt_fire = (rpt_cnt_reg == 32'(REPEAT_PERIOD_CYCLES - 1));
            else
                rpt_fire = (rpt_cnt_reg == 32'(REPEAT_DELAY_CYCLES - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || !rpt_held) begin
            rpt_cnt_reg   <= '0;
            rpt_armed_reg <= 1'b0;
        end else if (rpt_fire) begin
            rpt_cnt_reg   <= '0;
            rpt_armed_reg <= 1'b1;
        end else begin
            rpt_cnt_reg <= rpt_cnt_reg + 32'd1;
        end
    end

    assign up_evt   = press_evt[0] | (rpt_fire & ~key_level[0]);
    assign down_evt = press_evt[1] | (rpt_fire & key_level[0] & ~key_level[1]);
`else
    assign up_evt   = press_evt[0];
    assign down_evt = press_evt[1];
`endif

    always_comb begin
        state_next  = state_reg;
        offset_next = offset_reg;
        start_next  = start_reg;
        case (state_reg)
            S_IDLE: begin
                if (go_evt) begin
                    start_next  = {22'b0, sw};
                    offset_next = '0;
                    state_next  = S_LAUNCH;
                end
            end
            S_LAUNCH: state_next = S_RUN;
            S_RUN: begin
                if (done)
                    state_next = S_BROWSE;
            end
            S_BROWSE: begin
                // Priority go > home > up > down; only the winner acts.
                if (go_evt) begin
                    start_next  = {22'b0, sw};
                    offset_next = '0;
                    state_next  = S_LAUNCH;
                end else if (home_evt) begin
                    offset_next = '0;
                end else if (up_evt) begin
                    offset_next = (offset_reg == LAST_OFFSET) ? '0 : offset_reg + 1'b1;
                end else if (down_evt) begin
                    offset_next = (offset_reg == '0) ? LAST_OFFSET : offset_reg - 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= S_IDLE;
            offset_reg     <= '0;
            start_reg      <= '0;
            disp_start_reg <= '0;
            disp_count_reg <= '0;
            sat_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            offset_reg     <= offset_next;
            start_reg      <= start_next;
            disp_start_reg <= start_next[11:0] + {{(12-RAM_ADDR_BITS){1'b0}}, offset_next};
            if (state_next == S_BROWSE) begin
                disp_count_reg <= (count < 16'h1000) ? count[11:0] : 12'hFFF;
                sat_reg        <= (count >= 16'h1000);
            end else begin
                disp_count_reg <= '0;
                sat_reg        <= 1'b0;
            end
        end
    end

    assign go         = (state_reg == S_LAUNCH);
    assign start      = start_reg;
    assign n          = {{(12-RAM_ADDR_BITS){1'b0}}, offset_reg};
    assign disp_start = disp_start_reg;
    assign disp_count = disp_count_reg;
    assign ledr       = {6'b0, sat_reg, state_reg == S_BROWSE, state_reg == S_RUN, state_reg == S_IDLE};

endmodule

// File: tb/tb_collatz_range_ctrl.sv
// Randomized self-checking bench for collatz_range_ctrl with a range-engine stub and an offset/start reference model.
module tb_collatz_range_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  key = 4'hF;
    logic [9:0]  sw = '0;
    logic        done = 1'b0;
    logic [15:0] count = '0;
    logic        go;
    logic [31:0] start;
    logic [11:0] n;
    logic [11:0] disp_start;
    logic [11:0] disp_count;
    logic [9:0]  ledr;

    int vectors = 0;
    int miscompares = 0;
    int go_pulses = 0;
    int done_timer = 0;
    bit force_big = 1'b0;

    // Reference model: start value and offset as plain integers.
    int m_start = 0;
    int m_off = 0;

    always #5 clk = ~clk;

    collatz_range_ctrl #(
`ifdef COLLATZ_AUTO_REPEAT_EN
        .REPEAT_DELAY_CYCLES(40),
        .REPEAT_PERIOD_CYCLES(20),
`endif
        .DEBOUNCE_CYCLES(20'd4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .key(key), .sw(sw), .done(done), .count(count),
        .go(go), .start(start), .n(n), .disp_start(disp_start), .disp_count(disp_count), .ledr(ledr)
    );

    // Range engine stub: synchronous read of 3*n, done rises 50 cycles after go.
    always @(posedge clk) begin
        count <= force_big ? 16'h1234 : 16'(3 * n);
        if (go) begin
            done <= 1'b0;
            done_timer <= 50;
        end else if (done_timer > 0) begin
            done_timer <= done_timer - 1;
            if (done_timer == 1) done <= 1'b1;
        end
    end

    always @(negedge clk) if (go === 1'b1) go_pulses++;

    task automatic press(input logic [3:0] mask, input int hold);
        @(negedge clk) key = key & ~mask;
        repeat (hold) @(negedge clk);
        key = key | mask;
        repeat (14) @(negedge clk);
    endtask

    task automatic wait_browse(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ledr[2] === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (go !== 1'b0) begin miscompares++; $display("FAIL reset_go: got %b expected 0", go); end
        vectors++; if (start !== 32'h0) begin miscompares++; $display("FAIL reset_start: got %h expected 0", start); end
        vectors++; if (n !== 12'h0) begin miscompares++; $display("FAIL reset_n: got %h expected 0", n); end
        vectors++; if (disp_start !== 12'h0) begin miscompares++; $display("FAIL reset_disp_start: got %h expected 0", disp_start); end
        vectors++; if (disp_count !== 12'h0) begin miscompares++; $display("FAIL reset_disp_count: got %h expected 0", disp_count); end
        vectors++; if (ledr !== 10'b1) begin miscompares++; $display("FAIL reset_ledr: got %b expected 0000000001", ledr); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_launch;
        int g0;
        bit ok;
        g0 = go_pulses;
        sw = 10'h07B;
        press(4'b1000, 12);
        m_start = 'h07B; m_off = 0;
        vectors++; if (go_pulses - g0 !== 1) begin miscompares++; $display("FAIL launch_go_count: got %0d expected 1", go_pulses - g0); end
        vectors++; if (start !== 32'h7B) begin miscompares++; $display("FAIL launch_start: got %h expected 0000007b", start); end
        vectors++; if (ledr !== 10'b10) begin miscompares++; $display("FAIL launch_ledr_run: got %b expected 0000000010", ledr); end
        vectors++; if (disp_count !== 12'h0) begin miscompares++; $display("FAIL run_disp_count: got %h expected 0", disp_count); end
        sw = 10'($urandom);
        wait_browse(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL launch_browse_timeout: got no BROWSE expected BROWSE"); end
        repeat (3) @(negedge clk);
        vectors++; if (ledr !== 10'b100) begin miscompares++; $display("FAIL browse_ledr: got %b expected 0000000100", ledr); end
        vectors++; if (start !== 32'h7B) begin miscompares++; $display("FAIL sw_change_start: got %h expected 0000007b", start); end
        vectors++; if (disp_start !== 12'h07B) begin miscompares++; $display("FAIL browse_disp_start: got %h expected 07b", disp_start); end
        vectors++; if (disp_count !== 12'h0) begin miscompares++; $display("FAIL browse_disp_count: got %h expected 0", disp_count); end
    endtask

    task automatic test_browse_up;
        repeat (3) press(4'b0001, 12);
        m_off = 3;
        vectors++; if (n !== 12'd3) begin miscompares++; $display("FAIL up3_n: got %h expected 003", n); end
        vectors++; if (disp_start !== 12'h07E) begin miscompares++; $display("FAIL up3_disp_start: got %h expected 07e", disp_start); end
        vectors++; if (disp_count !== 12'h009) begin miscompares++; $display("FAIL up3_disp_count: got %h expected 009", disp_count); end
    endtask

    task automatic test_wrap;
        press(4'b0100, 12);
        m_off = 0;
        vectors++; if (n !== 12'd0) begin miscompares++; $display("FAIL home_n: got %h expected 000", n); end
        press(4'b0010, 12);
        m_off = 255;
        vectors++; if (n !== 12'd255) begin miscompares++; $display("FAIL down_wrap_n: got %h expected 0ff", n); end
        vectors++; if (disp_start !== 12'h17A) begin miscompares++; $display("FAIL down_wrap_disp_start: got %h expected 17a", disp_start); end
        vectors++; if (disp_count !== 12'h2FD) begin miscompares++; $display("FAIL down_wrap_disp_count: got %h expected 2fd", disp_count); end
        press(4'b0001, 12);
        m_off = 0;
        vectors++; if (n !== 12'd0) begin miscompares++; $display("FAIL up_wrap_n: got %h expected 000", n); end
        force_big = 1'b1;
        repeat (4) @(negedge clk);
        vectors++; if (disp_count !== 12'hFFF) begin miscompares++; $display("FAIL sat_disp_count: got %h expected fff", disp_count); end
        vectors++; if (ledr !== 10'b1100) begin miscompares++; $display("FAIL sat_ledr: got %b expected 0000001100", ledr); end
        force_big = 1'b0;
        repeat (4) @(negedge clk);
        vectors++; if (ledr[3] !== 1'b0) begin miscompares++; $display("FAIL unsat_ledr3: got %b expected 0", ledr[3]); end
    endtask

    task automatic test_priority;
        repeat (5) press(4'b0001, 12);
        m_off = 5;
        vectors++; if (n !== 12'd5) begin miscompares++; $display("FAIL prio_setup_n: got %h expected 005", n); end
        press(4'b0101, 12);
        m_off = 0;
        vectors++; if (n !== 12'd0) begin miscompares++; $display("FAIL prio_home_over_up: got %h expected 000", n); end
        for (int b = 1; b <= 3; b++) begin
            press(4'b0001, b);
            vectors++; if (n !== 12'd0) begin miscompares++; $display("FAIL bounce_%0d_n: got %h expected 000", b, n); end
        end
    endtask

    task automatic test_relaunch_run_ignore;
        int g0;
        bit ok;
        g0 = go_pulses;
        sw = 10'($urandom);
        press(4'b1000, 12);
        m_start = int'(sw); m_off = 0;
        sw = 10'($urandom);
        press(4'b1001, 12);
        vectors++; if (ledr !== 10'b10) begin miscompares++; $display("FAIL run_ignore_state: got %b expected 0000000010", ledr); end
        vectors++; if (go_pulses - g0 !== 1) begin miscompares++; $display("FAIL run_ignore_go: got %0d expected 1", go_pulses - g0); end
        wait_browse(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL relaunch_browse_timeout: got no BROWSE expected BROWSE"); end
        repeat (3) @(negedge clk);
        vectors++; if (start !== 32'(m_start)) begin miscompares++; $display("FAIL relaunch_start: got %h expected %h", start, m_start); end
        vectors++; if (n !== 12'd0) begin miscompares++; $display("FAIL run_ignore_n: got %h expected 000", n); end
        vectors++; if (disp_start !== 12'(m_start)) begin miscompares++; $display("FAIL relaunch_disp_start: got %h expected %h", disp_start, 12'(m_start)); end
    endtask

    task automatic test_random_browse;
        logic [3:0] mask;
        int r;
        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 5);
            case (r)
                0, 5: mask = 4'b0001;
                1:    mask = 4'b0010;
                2:    mask = 4'b0100;
                3:    mask = 4'b0011;
                default: mask = 4'b0110;
            endcase
            press(mask, $urandom_range(6, 14));
            if (mask[2]) m_off = 0;
            else if (mask[0]) m_off = (m_off + 1) % 256;
            else m_off = (m_off + 255) % 256;
            vectors++; if (n !== 12'(m_off)) begin miscompares++; $display("FAIL rand_n[%0d]: got %h expected %h", i, n, 12'(m_off)); end
            vectors++; if (disp_start !== 12'(m_start + m_off)) begin miscompares++; $display("FAIL rand_disp_start[%0d]: got %h expected %h", i, disp_start, 12'(m_start + m_off)); end
            vectors++; if (disp_count !== 12'(3 * m_off)) begin miscompares++; $display("FAIL rand_disp_count[%0d]: got %h expected %h", i, disp_count, 12'(3 * m_off)); end
        end
    endtask

`ifdef COLLATZ_AUTO_REPEAT_EN
    task automatic test_auto_repeat;
        // Hold of 90 cycles: press event plus repeats at +40, +60, +80.
        press(4'b0001, 90);
        m_off = (m_off + 4) % 256;
        vectors++; if (n !== 12'(m_off)) begin miscompares++; $display("FAIL repeat_n: got %h expected %h", n, 12'(m_off)); end
        repeat (60) @(negedge clk);
        vectors++; if (n !== 12'(m_off)) begin miscompares++; $display("FAIL repeat_release_n: got %h expected %h", n, 12'(m_off)); end
    endtask
`endif

    task automatic test_reset_midrun;
        int g0;
        sw = 10'($urandom);
        press(4'b1000, 12);
        vectors++; if (ledr !== 10'b10) begin miscompares++; $display("FAIL midrun_in_run: got %b expected 0000000010", ledr); end
        g0 = go_pulses;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        vectors++; if (ledr !== 10'b1) begin miscompares++; $display("FAIL midrun_ledr: got %b expected 0000000001", ledr); end
        vectors++; if (start !== 32'h0) begin miscompares++; $display("FAIL midrun_start: got %h expected 0", start); end
        vectors++; if (disp_start !== 12'h0) begin miscompares++; $display("FAIL midrun_disp_start: got %h expected 0", disp_start); end
        vectors++; if (disp_count !== 12'h0) begin miscompares++; $display("FAIL midrun_disp_count: got %h expected 0", disp_count); end
        repeat (60) @(negedge clk);
        vectors++; if (ledr !== 10'b1) begin miscompares++; $display("FAIL stale_done_ledr: got %b expected 0000000001", ledr); end
        vectors++; if (go_pulses !== g0) begin miscompares++; $display("FAIL stale_done_go: got %0d expected %0d", go_pulses, g0); end
        vectors++; if (n !== 12'h0) begin miscompares++; $display("FAIL stale_done_n: got %h expected 0", n); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_launch();
        test_browse_up();
        test_wrap();
        test_priority();
        test_relaunch_run_ignore();
        test_random_browse();
`ifdef COLLATZ_AUTO_REPEAT_EN
        test_auto_repeat();
`endif
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
